// File: rtl/id_ex_operand_stage_pkg.sv
// id_ex_operand_stage_pkg: shared widths, ALU opcodes and forward-select encoding for the ID/EX stage.
package id_ex_operand_stage_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_ADDB = 4'b1000;
  localparam logic [3:0] ALU_ADDBS = 4'b1001;
  localparam logic [3:0] ALU_SLL = 4'b1010;
  localparam logic [3:0] ALU_SRL = 4'b1011;
  localparam logic [3:0] ALU_SRA = 4'b1100;
  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;
endpackage

// File: rtl/id_ex_operand_stage_forward_unit.sv
// forward_unit: combinational MEM/WB forwarding selects and load-use hazard detection.
module forward_unit
  import id_ex_operand_stage_pkg::*;
#(
  parameter int RA = REG_ADDR_WIDTH
) (
  input  logic [RA-1:0] rs_e,
  input  logic [RA-1:0] rt_e,
  input  logic [RA-1:0] rs_d,
  input  logic [RA-1:0] rt_d,
  input  logic [RA-1:0] write_reg_m,
  input  logic [RA-1:0] write_reg_w,
  input  logic          mem_to_reg_e,
  input  logic          reg_write_m,
  input  logic          reg_write_w,
  output fwd_sel_e      forward_a_e,
  output fwd_sel_e      forward_b_e,
  output logic          lwstall
);
  logic m_ok, w_ok;
  always_comb begin
    m_ok = reg_write_m && write_reg_m != '0;
    w_ok = reg_write_w && write_reg_w != '0;
    forward_a_e = (m_ok && write_reg_m == rs_e) ? FWD_MEM : (w_ok && write_reg_w == rs_e) ? FWD_WB : FWD_REG;
    forward_b_e = (m_ok && write_reg_m == rt_e) ? FWD_MEM : (w_ok && write_reg_w == rt_e) ? FWD_WB : FWD_REG;
    lwstall = mem_to_reg_e && rt_e != '0 && (rt_e == rs_d || rt_e == rt_d);
  end
endmodule

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX register with forwarding, operand muxing and load-use stall.
// Define LOADUSE_CNT_EN to add the BubbleCount load-use bubble counter output.
module id_ex_operand_stage
  import id_ex_operand_stage_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH,
  parameter int RA = REG_ADDR_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] RD1D,
  input  logic [WIDTH-1:0] RD2D,
  input  logic [WIDTH-1:0] SignImmD,
  input  logic [4:0]       ShamtD,
  input  logic [RA-1:0]    RsD,
  input  logic [RA-1:0]    RtD,
  input  logic [RA-1:0]    RdD,
  input  logic [3:0]       ALUControlD,
  input  logic             ALUSrcD,
  input  logic             ShiftSrcD,
  input  logic             RegDstD,
  input  logic             RegWriteD,
  input  logic             MemtoRegD,
  input  logic             MemWriteD,
  input  logic             FlushE,
  input  logic             StallE,
  input  logic [WIDTH-1:0] ALUOutM,
  input  logic [RA-1:0]    WriteRegM,
  input  logic             RegWriteM,
  input  logic [WIDTH-1:0] ResultW,
  input  logic [RA-1:0]    WriteRegW,
  input  logic             RegWriteW,
  output logic [WIDTH-1:0] SrcAE,
  output logic [WIDTH-1:0] SrcBE,
  output logic [3:0]       ALUControlE,
  output logic [WIDTH-1:0] WriteDataE,
  output logic [RA-1:0]    WriteRegE,
  output logic             RegWriteE,
  output logic             MemtoRegE,
  output logic             MemWriteE,
  output logic             StallD
`ifdef LOADUSE_CNT_EN
  ,
  output logic [31:0]      BubbleCount
`endif
);
  typedef struct packed {
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic [WIDTH-1:0] imm;
    logic [4:0]       shamt;
    logic [RA-1:0]    rs;
    logic [RA-1:0]    rt;
    logic [RA-1:0]    rd;
    logic [3:0]       alu_ctl;
    logic             alu_src;
    logic             shift_src;
    logic             reg_dst;
    logic             reg_write;
    logic             mem_to_reg;
    logic             mem_write;
  } e_t;
  e_t e_q, e_d, d_in;
  fwd_sel_e fwd_a_sel, fwd_b_sel;
  logic lwstall;
  logic [WIDTH-1:0] fwd_a, fwd_b;
  forward_unit #(.RA(RA)) u_fwd (
    .rs_e(e_q.rs), .rt_e(e_q.rt), .rs_d(RsD), .rt_d(RtD),
    .write_reg_m(WriteRegM), .write_reg_w(WriteRegW),
    .mem_to_reg_e(e_q.mem_to_reg), .reg_write_m(RegWriteM), .reg_write_w(RegWriteW),
    .forward_a_e(fwd_a_sel), .forward_b_e(fwd_b_sel), .lwstall(lwstall)
  );
  always_comb begin
    d_in = '{rd1: RD1D, rd2: RD2D, imm: SignImmD, shamt: ShamtD, rs: RsD, rt: RtD, rd: RdD,
             alu_ctl: ALUControlD, alu_src: ALUSrcD, shift_src: ShiftSrcD, reg_dst: RegDstD,
             reg_write: RegWriteD, mem_to_reg: MemtoRegD, mem_write: MemWriteD};
    e_d = StallE ? e_q : (FlushE || lwstall) ? '0 : d_in;
    fwd_a = fwd_a_sel == FWD_MEM ? ALUOutM : fwd_a_sel == FWD_WB ? ResultW : e_q.rd1;
    fwd_b = fwd_b_sel == FWD_MEM ? ALUOutM : fwd_b_sel == FWD_WB ? ResultW : e_q.rd2;
  end
  always_ff @(posedge clk) e_q <= reset ? '0 : e_d;
  assign SrcAE = e_q.shift_src ? {{(WIDTH-5){1'b0}}, e_q.shamt} : fwd_a;
  assign SrcBE = e_q.alu_src ? e_q.imm : fwd_b;
  assign WriteDataE = fwd_b;
  assign ALUControlE = e_q.alu_ctl;
  assign WriteRegE = e_q.reg_dst ? e_q.rd : e_q.rt;
  assign RegWriteE = e_q.reg_write;
  assign MemtoRegE = e_q.mem_to_reg;
  assign MemWriteE = e_q.mem_write;
  assign StallD = lwstall || StallE;
`ifdef LOADUSE_CNT_EN
  logic [31:0] cnt_q, cnt_d;
  always_comb cnt_d = (lwstall && !StallE) ? cnt_q + 32'd1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
  assign BubbleCount = cnt_q;
`endif
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb_id_ex_operand_stage: directed scoreboard bench for the ID/EX operand stage.
module tb_id_ex_operand_stage;
  logic clk = 1'b0, reset;
  logic [31:0] RD1D, RD2D, SignImmD, ALUOutM, ResultW;
  logic [4:0] ShamtD, RsD, RtD, RdD, WriteRegM, WriteRegW;
  logic [3:0] ALUControlD;
  logic ALUSrcD, ShiftSrcD, RegDstD, RegWriteD, MemtoRegD, MemWriteD, FlushE, StallE, RegWriteM, RegWriteW;
  logic [31:0] SrcAE, SrcBE, WriteDataE;
  logic [3:0] ALUControlE;
  logic [4:0] WriteRegE;
  logic RegWriteE, MemtoRegE, MemWriteE, StallD;
`ifdef LOADUSE_CNT_EN
  logic [31:0] BubbleCount;
`endif
  int tests = 0, fails = 0;

  typedef struct packed {
    logic [31:0] a, b, wd;
    logic [3:0] alu;
    logic [4:0] wreg;
    logic rw, m2r, mw;
  } obs_t;
  obs_t exp_q[$];

  id_ex_operand_stage dut (
    .clk(clk), .reset(reset), .RD1D(RD1D), .RD2D(RD2D), .SignImmD(SignImmD), .ShamtD(ShamtD),
    .RsD(RsD), .RtD(RtD), .RdD(RdD), .ALUControlD(ALUControlD), .ALUSrcD(ALUSrcD), .ShiftSrcD(ShiftSrcD),
    .RegDstD(RegDstD), .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
    .FlushE(FlushE), .StallE(StallE), .ALUOutM(ALUOutM), .WriteRegM(WriteRegM), .RegWriteM(RegWriteM),
    .ResultW(ResultW), .WriteRegW(WriteRegW), .RegWriteW(RegWriteW), .SrcAE(SrcAE), .SrcBE(SrcBE),
    .ALUControlE(ALUControlE), .WriteDataE(WriteDataE), .WriteRegE(WriteRegE), .RegWriteE(RegWriteE),
    .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE), .StallD(StallD)
`ifdef LOADUSE_CNT_EN
    , .BubbleCount(BubbleCount)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, b, wd, input logic [3:0] alu, input logic [4:0] wreg, input logic rw, m2r, mw);
    exp_q.push_back('{a: a, b: b, wd: wd, alu: alu, wreg: wreg, rw: rw, m2r: m2r, mw: mw});
  endtask

  task automatic check_e(input string tag);
    obs_t e;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, ".SrcAE"}, SrcAE, e.a);
      chk({tag, ".SrcBE"}, SrcBE, e.b);
      chk({tag, ".WriteDataE"}, WriteDataE, e.wd);
      chk({tag, ".ALUControlE"}, {28'd0, ALUControlE}, {28'd0, e.alu});
      chk({tag, ".WriteRegE"}, {27'd0, WriteRegE}, {27'd0, e.wreg});
      chk({tag, ".RegWriteE"}, {31'd0, RegWriteE}, {31'd0, e.rw});
      chk({tag, ".MemtoRegE"}, {31'd0, MemtoRegE}, {31'd0, e.m2r});
      chk({tag, ".MemWriteE"}, {31'd0, MemWriteE}, {31'd0, e.mw});
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic [31:0] rd1, rd2, imm, input logic [4:0] shamt, rs, rt, rd,
                       input logic [3:0] alu, input logic alu_src, shift_src, reg_dst, rw, m2r, mw);
    RD1D = rd1; RD2D = rd2; SignImmD = imm; ShamtD = shamt; RsD = rs; RtD = rt; RdD = rd;
    ALUControlD = alu; ALUSrcD = alu_src; ShiftSrcD = shift_src; RegDstD = reg_dst;
    RegWriteD = rw; MemtoRegD = m2r; MemWriteD = mw;
  endtask

  initial begin
    reset = 1'b1; FlushE = 1'b0; StallE = 1'b0;
    ALUOutM = '0; WriteRegM = '0; RegWriteM = 1'b0; ResultW = '0; WriteRegW = '0; RegWriteW = 1'b0;
    set_d(32'd5, 32'd7, 32'h10, 5'd3, 5'd3, 5'd4, 5'd9, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step();
    step();
    push(0, 0, 0, 4'd0, 5'd0, 0, 0, 0);
    check_e("reset");
    chk("reset.StallD", {31'd0, StallD}, 32'd0);
`ifdef LOADUSE_CNT_EN
    chk("reset.BubbleCount", BubbleCount, 32'd0);
`endif
    reset = 1'b0;
    set_d(32'd5, 32'd7, 32'h10, 5'd0, 5'd3, 5'd4, 5'd9, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    push(32'd5, 32'd7, 32'd7, 4'b0010, 5'd9, 1, 0, 0);
    step();
    check_e("add");
    RegWriteM = 1'b1; WriteRegM = 5'd3; ALUOutM = 32'hAAAA0000;
    RegWriteW = 1'b1; WriteRegW = 5'd3; ResultW = 32'h1234;
    #1;
    push(32'hAAAA0000, 32'd7, 32'd7, 4'b0010, 5'd9, 1, 0, 0);
    check_e("fwd_mem_prio");
    RegWriteM = 1'b0;
    #1;
    push(32'h1234, 32'd7, 32'd7, 4'b0010, 5'd9, 1, 0, 0);
    check_e("fwd_wb");
    RegWriteW = 1'b0;
    set_d(32'd0, 32'd11, 32'd0, 5'd0, 5'd0, 5'd0, 5'd0, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(32'd0, 32'd11, 32'd11, 4'b0110, 5'd0, 0, 0, 0);
    step();
    RegWriteM = 1'b1; WriteRegM = 5'd0; ALUOutM = 32'hDEAD;
    #1;
    check_e("no_r0_fwd");
    RegWriteM = 1'b0;
    set_d(32'd100, 32'd0, 32'd4, 5'd0, 5'd2, 5'd8, 5'd0, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    push(32'd100, 32'd4, 32'd0, 4'b0010, 5'd8, 1, 1, 0);
    step();
    check_e("lw");
    set_d(32'h55, 32'd6, 32'd0, 5'd0, 5'd8, 5'd9, 5'd10, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    chk("lwstall.StallD", {31'd0, StallD}, 32'd1);
`ifdef LOADUSE_CNT_EN
    chk("lwstall.BubbleCount0", BubbleCount, 32'd0);
`endif
    push(0, 0, 0, 4'd0, 5'd0, 0, 0, 0);
    step();
    check_e("bubble");
    chk("bubble.StallD", {31'd0, StallD}, 32'd0);
`ifdef LOADUSE_CNT_EN
    chk("bubble.BubbleCount1", BubbleCount, 32'd1);
`endif
    step();
    RegWriteM = 1'b1; WriteRegM = 5'd8; ALUOutM = 32'h77;
    #1;
    push(32'h77, 32'd6, 32'd6, 4'b0000, 5'd10, 1, 0, 0);
    check_e("lw_fwd_mem");
    chk("lw_fwd.StallD", {31'd0, StallD}, 32'd0);
    RegWriteM = 1'b0;
    #1;
    StallE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_d($urandom, $urandom, $urandom, 5'(i + 1), 5'(i + 11), 5'(i + 20), 5'd1, 4'b0011, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      push(32'h55, 32'd6, 32'd6, 4'b0000, 5'd10, 1, 0, 0);
      step();
      check_e($sformatf("stall%0d", i));
      chk($sformatf("stall%0d.StallD", i), {31'd0, StallD}, 32'd1);
    end
    FlushE = 1'b1;
    push(32'h55, 32'd6, 32'd6, 4'b0000, 5'd10, 1, 0, 0);
    step();
    check_e("stall_flush");
    StallE = 1'b0;
    push(0, 0, 0, 4'd0, 5'd0, 0, 0, 0);
    step();
    check_e("flush");
`ifdef LOADUSE_CNT_EN
    chk("flush.BubbleCount", BubbleCount, 32'd1);
`endif
    FlushE = 1'b0;
    set_d(32'h99, 32'h80000000, 32'd0, 5'd4, 5'd1, 5'd5, 5'd0, 4'b1100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    push(32'd4, 32'h80000000, 32'h80000000, 4'b1100, 5'd5, 1, 0, 0);
    step();
    check_e("sra_shamt");
    StallE = 1'b1;
    push(32'd4, 32'h80000000, 32'h80000000, 4'b1100, 5'd5, 1, 0, 0);
    step();
    check_e("pre_reset_stall");
    reset = 1'b1;
    push(0, 0, 0, 4'd0, 5'd0, 0, 0, 0);
    step();
    reset = 1'b0;
    check_e("reset_mid_stall");
    chk("reset_mid_stall.StallD", {31'd0, StallD}, 32'd1);
    StallE = 1'b0;
    #1;
    chk("release.StallD", {31'd0, StallD}, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
